// File: rtl/layer2_pool_reader_pkg.sv
// Shared constants and FSM encoding for the layer-2 pooling reader.
package layer2_pkg;

    localparam int unsigned DATA_W     = 18;
    localparam int unsigned MAP_DIM    = 16;
    localparam int unsigned POOL_DIM   = MAP_DIM / 2;
    localparam int unsigned BANK_DEPTH = 256;
    localparam int unsigned ADDR_W     = 9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/layer2_pool_reader_addr_gen.sv
// Combinational read-address generator for one 2x2 pooling window.
// k selects the tap in issue order: 0 -> (0,0), 1 -> (0,1), 2 -> (1,0), 3 -> (1,1).
module pool_addr_gen #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned MAP_DIM = 16,
    parameter int unsigned CNT_W   = 3
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  r,
    input  logic [CNT_W-1:0]  c,
    input  logic [1:0]        k,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] col_off;
    logic [ADDR_W-1:0] tap_off;

    // Window origin is (2r, 2c) in the map; the tap adds a row and/or column.
    always_comb begin
        row_off = ADDR_W'(r) * ADDR_W'(2 * MAP_DIM);
        col_off = ADDR_W'(c) << 1;
        tap_off = (k[1] ? ADDR_W'(MAP_DIM) : '0) + ADDR_W'(k[0]);
        addr    = base + row_off + col_off + tap_off;
    end

endmodule

// File: rtl/layer2_pool_reader.sv
// Reads a completed 16x16 map from one ping-pong bank, applies 2x2/stride-2
// signed max pooling and streams 64 results over a valid/ready handshake.
module layer2_pool_reader #(
    parameter int unsigned DATA_W     = layer2_pkg::DATA_W,
    parameter int unsigned MAP_DIM    = layer2_pkg::MAP_DIM,
    parameter int unsigned BANK_DEPTH = layer2_pkg::BANK_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 map_ready,
    input  logic                                 map_bank,
    output logic                                 ram_rd,
    output logic [$clog2(2*BANK_DEPTH)-1:0]      ram_addr,
    input  logic signed [DATA_W-1:0]             ram_dout,
    output logic signed [DATA_W-1:0]             out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 pool_done,
    output logic                                 overrun
);

    import layer2_pkg::*;

    localparam int unsigned PD = MAP_DIM / 2;
    localparam int unsigned CW = $clog2(PD);
    localparam int unsigned AW = $clog2(2 * BANK_DEPTH);

    state_t state, state_next;

    logic                     prev;
    logic                     start_edge;
    logic [AW-1:0]            base;
    logic [AW-1:0]            gen_addr;
    logic [AW-1:0]            addr_hold;
    logic [CW-1:0]            r;
    logic [CW-1:0]            c;
    logic [1:0]               k;
    logic [1:0]               k_q;
    logic                     rd_q;
    logic                     handshake;
    logic                     last_window;
    logic signed [DATA_W-1:0] max_q;

    assign start_edge  = map_ready & ~prev;
    assign handshake   = (state == OUT) && out_ready;
    assign last_window = (r == CW'(PD - 1)) && (c == CW'(PD - 1));
    assign out_data    = max_q;

    pool_addr_gen #(
        .ADDR_W (AW),
        .MAP_DIM(MAP_DIM),
        .CNT_W  (CW)
    ) u_addr_gen (
        .base(base),
        .r   (r),
        .c   (c),
        .k   (k),
        .addr(gen_addr)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        ram_rd     = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;
        pool_done  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_edge) begin
                    state_next = READ;
                end
            end
            READ: begin
                ram_rd = 1'b1;
                if (k == 2'd3) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = last_window ? DONE : READ;
                end
            end
            DONE: begin
                pool_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address port shows the live address while reading, otherwise the last one issued.
    always_comb begin
        ram_addr = ram_rd ? gen_addr : addr_hold;
    end

    // Start/overrun detection, bank base latch and address hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= 1'b1;
            base      <= '0;
            addr_hold <= '0;
            overrun   <= 1'b0;
        end else begin
            prev <= map_ready;
            if (start_edge) begin
                if (state == IDLE) begin
                    base <= map_bank ? AW'(BANK_DEPTH) : '0;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (state == READ) begin
                addr_hold <= gen_addr;
            end
        end
    end

    // Window and tap counters; r/c advance only on an accepted output.
    // Wrapping r past the last row returns both counters to 0 for the next pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
            k <= '0;
        end else begin
            if ((state == IDLE) && start_edge) begin
                r <= '0;
                c <= '0;
                k <= '0;
            end else if (state == READ) begin
                k <= k + 2'd1;
            end else if (handshake) begin
                if (c == CW'(PD - 1)) begin
                    c <= '0;
                    r <= r + CW'(1);
                end else begin
                    c <= c + CW'(1);
                end
            end
        end
    end

    // Running signed max over the four data returning one cycle after each issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= 1'b0;
            k_q   <= '0;
            max_q <= '0;
        end else begin
            rd_q <= ram_rd;
            k_q  <= k;
            if (rd_q) begin
                if ((k_q == 2'd0) || (ram_dout > max_q)) begin
                    max_q <= ram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer2_pool_reader.sv
// Directed bench for layer2_pool_reader with a behavioural RAM and an output scoreboard.
module tb_layer2_pool_reader;

    logic               clk = 1'b0;
    logic               rst;
    logic               map_ready;
    logic               map_bank;
    logic               ram_rd;
    logic [8:0]         ram_addr;
    logic signed [17:0] ram_dout;
    logic signed [17:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               pool_done;
    logic               overrun;

    logic signed [17:0] mem [0:511];
    logic signed [17:0] exp_q [$];
    logic [8:0]         addr_log [$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int t0;
    int first_rd_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
    int n_out, bad_addr;
    logic cur_bank;

    layer2_pool_reader #(
        .DATA_W    (18),
        .MAP_DIM   (16),
        .BANK_DEPTH(256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .map_ready(map_ready),
        .map_bank (map_bank),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .pool_done(pool_done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer read port, one-cycle latency.
    always @(posedge clk) begin
        if (ram_rd) ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ram_rd) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (addr_log.size() < 4) addr_log.push_back(ram_addr);
                if (ram_addr[8] !== cur_bank) bad_addr++;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pool_done) done_cyc = cyc;
            if (out_valid && out_ready) begin
                last_hs_cyc = cyc;
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic signed [17:0] win_max(input int base, input int r, input int c);
        int a;
        logic signed [17:0] m;
        a = base + 32 * r + 2 * c;
        m = mem[a];
        if (mem[a + 1]  > m) m = mem[a + 1];
        if (mem[a + 16] > m) m = mem[a + 16];
        if (mem[a + 17] > m) m = mem[a + 17];
        return m;
    endfunction

    task automatic push_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp_q.push_back(18'(32 * r + 2 * c + 17));
    endtask

    task automatic start_pass(input logic bank);
        @(posedge clk); #1;
        first_rd_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        n_out = 0; bad_addr = 0; addr_log.delete(); cur_bank = bank;
        map_bank = bank; map_ready = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        map_ready = 1'b0; map_bank = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cyc < 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", (done_cyc >= 0), 1);
    endtask

    task automatic check_pass(input logic timed, input int a0, input int a1, input int a2, input int a3);
        if (timed) begin
            chk("first_issue_cyc", first_rd_cyc, t0 + 1);
            chk("first_valid_cyc", first_valid_cyc, t0 + 6);
            chk("last_hs_cyc", last_hs_cyc, t0 + 384);
            chk("done_cyc", done_cyc, t0 + 385);
            chk("busy_after_done", busy, 0);
        end
        chk("n_outputs", n_out, 64);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("addr_out_of_bank", bad_addr, 0);
        chk("addr0", (addr_log.size() > 0) ? int'(addr_log[0]) : -1, a0);
        chk("addr1", (addr_log.size() > 1) ? int'(addr_log[1]) : -1, a1);
        chk("addr2", (addr_log.size() > 2) ? int'(addr_log[2]) : -1, a2);
        chk("addr3", (addr_log.size() > 3) ? int'(addr_log[3]) : -1, a3);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_rd"}, ram_rd, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pool_done"}, pool_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic signed [17:0] held;
        int guard;

        first_rd_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        n_out = 0; bad_addr = 0; cur_bank = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 18'(i);
        for (int i = 256; i < 512; i++) mem[i] = 18'(-i);

        // Reset with map_ready held high: level must not start a pass.
        rst = 1'b1; map_ready = 1'b1; map_bank = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("level_high_no_start", busy, 0);
        map_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Pass A: ramp in bank 0, continuous ready.
        push_ramp();
        start_pass(1'b0);
        wait_done(1000);
        check_pass(1'b1, 0, 1, 16, 17);

        // Pass B: random data in bank 1 with signed-compare windows, backpressure at window 5.
        for (int i = 256; i < 512; i++) mem[i] = 18'($urandom);
        mem[256] = -18'sd5;  mem[257] = -18'sd3;  mem[272] = -18'sd7;  mem[273] = -18'sd100;
        mem[258] = -18'sd1;  mem[259] = 18'sd0;   mem[274] = 18'sh20000; mem[275] = 18'sd131071;
        exp_q.push_back(-18'sd3);
        exp_q.push_back(18'sd131071);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (r != 0 || c > 1) exp_q.push_back(win_max(256, r, c));
        start_pass(1'b1);
        guard = 0;
        while (n_out < 5 && guard < 200) begin @(posedge clk); #1; guard++; end
        chk("reach_window5", n_out, 5);
        out_ready = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("window5_valid", out_valid, 1);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, held);
            chk("bp_no_read", ram_rd, 0);
        end
        chk("bp_no_handshake", n_out, 5);
        @(posedge clk); #1; out_ready = 1'b1;
        wait_done(1000);
        check_pass(1'b0, 256, 257, 272, 273);

        // Pass C: ramp again with an extra start pulse mid-pass.
        push_ramp();
        start_pass(1'b0);
        guard = 0;
        while (cyc < t0 + 100 && guard < 200) begin @(posedge clk); #1; guard++; end
        map_ready = 1'b1;
        @(posedge clk); #1; map_ready = 1'b0;
        chk("overrun_set", overrun, 1);
        wait_done(1000);
        check_pass(1'b1, 0, 1, 16, 17);
        done_cyc = -1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_second_pass_busy", busy, 0);
        chk("no_second_pass_done", done_cyc, -1);
        chk("overrun_sticky", overrun, 1);

        // Pass D: reset mid-pass, then level-high map_ready must not restart.
        push_ramp();
        start_pass(1'b0);
        guard = 0;
        while (cyc < t0 + 50 && guard < 200) begin @(posedge clk); #1; guard++; end
        map_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero("midpass_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_level_no_start", busy, 0);
        map_ready = 1'b0;
        repeat (2) @(posedge clk);
        push_ramp();
        start_pass(1'b0);
        wait_done(1000);
        check_pass(1'b1, 0, 1, 16, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer2_pool_reader.md
# layer2_pool_reader

Reads a completed 16x16 feature map from one bank of the layer-2 ping-pong buffer, which is 512 x 18-bit with banks at 0–255 and 256–511. It applies 2x2 stride-2 signed max pooling and streams 64 pooled values to the next layer over a valid/ready handshake. It sits directly downstream of the layer-2 save stage. It starts on that stage's map-complete indication and reads through the buffer's read port, which has 1-cycle latency.

## Interface
Parameters:
- DATA_W, 18, signed sample width
- MAP_DIM, 16, input map side; the output side is MAP_DIM/2
- BANK_DEPTH, 256, words per bank; must equal MAP_DIM*MAP_DIM

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- map_ready  in  1  completion indication from the save stage; a rising edge starts a pass
- map_bank  in  1  bank holding the completed map; sampled in the rising-edge cycle of map_ready
- ram_rd  out  1  buffer read strobe
- ram_addr  out  9  buffer read address
- ram_dout  in  DATA_W  signed read data; valid the cycle after ram_rd
- out_data  out  DATA_W  signed pooled value
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- busy  out  1  pass in progress
- pool_done  out  1  one-cycle pulse at the end of a pass
- overrun  out  1  sticky error flag; cleared only by rst

## Operation
- Edge detect: the prev register samples map_ready every cycle and resets to 1. A map_ready level held high through reset therefore does not start a pass.
- FSM states:
  - IDLE
  - READ: 4 issue cycles
  - WAIT: last datum returns
  - OUT: hold until handshake
  - DONE
- IDLE -> READ on a map_ready rising edge. On that edge, latch base = map_bank*BANK_DEPTH and clear the window counters r and c to 0.
- Window (r,c), with r,c in 0..7: addresses are base + 32r + 2c + k for k = 0, 1, 16, 17, issued in that order with ram_rd=1.
- Max: the first returned datum loads the running max. Each later datum replaces it if the datum is larger, using a signed compare. On ties the earlier value is kept (the value is the same).
- OUT: out_data = max and out_valid = 1 until out_ready is seen high.
  - On handshake with c<7: c++ and go to READ.
  - On handshake with c=7, r<7: c=0, r++ and go to READ.
  - On handshake with (7,7): go to DONE.
- Output order is raster: r-major, then c.
- DONE: pool_done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- A map_ready rising edge while busy sets overrun and is otherwise ignored. The pass in flight continues unchanged.
- No arithmetic widening: pooling only selects among inputs, so out_data width is DATA_W.

## Timing
- Reset values: ram_rd=0, ram_addr=0, out_data=0, out_valid=0, busy=0, pool_done=0, overrun=0, state IDLE, counters 0.
- Cycle T is the cycle in which the map_ready rising edge is seen.
  - Issues occur in T+1..T+4.
  - Data arrives in T+2..T+5.
  - out_valid is high from T+6.
- Windows do not overlap. With out_ready held high, each window takes 6 cycles. The last handshake falls at T+384, pool_done is high at T+385, and busy is low from T+386.
- While out_valid=1 and out_ready=0, out_data, ram_rd (held at 0) and the counters hold stable.
- ram_rd=0 in every state except READ. ram_addr holds its last value when not reading.
- rst asserted mid-pass aborts immediately to the reset values. No partial output is flagged.

## Structure
- Package layer2_pkg holds:
  - DATA_W, MAP_DIM, POOL_DIM (=8), BANK_DEPTH, ADDR_W (=9)
  - the FSM state enum: IDLE, READ, WAIT, OUT, DONE
- Sub-module pool_addr_gen takes base, r, c and k (2 bits) and produces ram_addr. It is purely combinational. The FSM and the counters stay in the top module.

## Test plan
- Ramp bank 0 with mem[i]=i, map_bank=0, out_ready=1:
  - output is 64 values 17, 19, ..., 31, 49, ..., with window (r,c) = 32r+2c+17
  - pool_done is high at T+385
- Signed compare: a window holding -5, -3, -7, -100 outputs -3. A window holding -1, 0, -131072, 131071 outputs 131071.
- Bank select: map_bank=1 produces ram_addr only in 256..511. The first four addresses are 256, 257, 272, 273.
- Backpressure: drop out_ready for 10 cycles at window 5. out_data and out_valid stay stable, no ram_rd is issued, and the sequence resumes intact.
- Overrun: pulse map_ready at T+100. overrun=1 and stays 1, the original pass completes with 64 outputs, and no second pass starts.
- Reset mid-pass: assert rst at T+50. All outputs are 0 the same cycle. After release, a level-high map_ready does not start a pass. Low followed by high starts a fresh pass from window (0,0).
